// File: rtl/wb_port_arbiter.sv
// Two-source writeback arbiter onto the single register-file write port.
// Source A has fixed priority; a starvation counter forces source B ahead after STARVE_LIMIT waits.
module wb_port_arbiter #(
   parameter int DATA_W       = 64,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              wb_src,
   output logic              b_starved
);

   // Handshake: a write moves in any cycle where valid && ready. Readies are
   // combinational from the valids and the FSM state, are never both high, and
   // are held low while reset is asserted; requesters hold rd/data until accepted.

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {
      A_PRI   = 1'b0,
      B_FORCE = 1'b1
   } arbState_t;

   arbState_t         state;
   arbState_t         stateNext;
   logic [3:0]        starveCnt;
   logic [3:0]        starveCntNext;
   logic              aXfer;
   logic              bXfer;
   logic [ADDR_W-1:0] winRd;
   logic [DATA_W-1:0] winData;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= A_PRI;
         starveCnt <= 4'd0;
      end else begin
         state     <= stateNext;
         starveCnt <= starveCntNext;
      end
   end

   always_comb begin
      a_ready       = 1'b0;
      b_ready       = 1'b0;
      stateNext     = state;
      starveCntNext = 4'd0;

      if (!reset) begin
         case (state)
            A_PRI: begin
               a_ready = a_valid;
               b_ready = b_valid && !a_valid;
            end
            B_FORCE: begin
               b_ready = b_valid;
               a_ready = a_valid && !b_valid;
            end
            default: ;
         endcase
      end

      if (b_valid && !b_ready)
         starveCntNext = (starveCnt >= LIMIT) ? LIMIT : starveCnt + 4'd1;

      case (state)
         A_PRI:   if (starveCntNext == LIMIT) stateNext = B_FORCE;
         // Leave on the forced transfer, or recover if B withdraws its request.
         B_FORCE: if ((b_valid && b_ready) || !b_valid) stateNext = A_PRI;
         default: stateNext = A_PRI;
      endcase
   end

   assign aXfer     = a_valid && a_ready;
   assign bXfer     = b_valid && b_ready;
   assign winRd     = bXfer ? b_rd : a_rd;
   assign winData   = bXfer ? b_data : a_data;
   assign b_starved = (state == B_FORCE);

   // A transfer to x0 completes the handshake but leaves the port untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         wb_src   <= 1'b0;
      end else if ((aXfer || bXfer) && (winRd != '0)) begin
         rf_we    <= 1'b1;
         rf_waddr <= winRd;
         rf_wdata <= winData;
         wb_src   <= bXfer;
      end else begin
         rf_we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_wb_port_arbiter;

   localparam int DATA_W       = 64;
   localparam int ADDR_W       = 5;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_rd;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_rd;
   logic [DATA_W-1:0] b_data;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              wb_src;
   logic              b_starved;

   int checkCnt = 0;
   int errorCnt = 0;
   logic [DATA_W-1:0] expQ[$];
   logic [DATA_W-1:0] expData;

   wb_port_arbiter #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_rd     (a_rd),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_rd     (b_rd),
      .b_data   (b_data),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .wb_src   (wb_src),
      .b_starved(b_starved)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         errorCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic driveA(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
      a_valid = v;
      a_rd    = rd;
      a_data  = d;
   endtask

   task automatic driveB(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
      b_valid = v;
      b_rd    = rd;
      b_data  = d;
   endtask

   task automatic checkRf(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic src);
      checkVal({tag, "_we"},    64'(rf_we),    64'(we));
      checkVal({tag, "_waddr"}, 64'(rf_waddr), 64'(addr));
      checkVal({tag, "_wdata"}, rf_wdata,      data);
      checkVal({tag, "_src"},   64'(wb_src),   64'(src));
   endtask

   initial begin
      // Reset state, with requests present to confirm readies stay low.
      reset = 1'b1;
      driveA(1'b1, 5'd1, 64'h1);
      driveB(1'b1, 5'd2, 64'h2);
      step();
      checkVal("rst_aRdy", 64'(a_ready), 64'd0);
      checkVal("rst_bRdy", 64'(b_ready), 64'd0);
      checkVal("rst_starved", 64'(b_starved), 64'd0);
      checkRf("rst", 1'b0, 5'd0, 64'd0, 1'b0);
      driveA(1'b0, 5'd0, 64'd0);
      driveB(1'b0, 5'd0, 64'd0);
      reset = 1'b0;
      step();

      // A only.
      driveA(1'b1, 5'd7, 64'hBBBBBBBBBBBBBBBB);
      #1;
      checkVal("t1_aRdy", 64'(a_ready), 64'd1);
      checkVal("t1_bRdy", 64'(b_ready), 64'd0);
      step();
      driveA(1'b0, 5'd0, 64'd0);
      checkRf("t1", 1'b1, 5'd7, 64'hBBBBBBBBBBBBBBBB, 1'b0);

      // B only.
      driveB(1'b1, 5'd12, 64'hDEADBEEFDEADBEEF);
      #1;
      checkVal("t2_bRdy", 64'(b_ready), 64'd1);
      checkVal("t2_aRdy", 64'(a_ready), 64'd0);
      step();
      driveB(1'b0, 5'd0, 64'd0);
      checkRf("t2", 1'b1, 5'd12, 64'hDEADBEEFDEADBEEF, 1'b1);
      step();
      checkRf("t2_idle", 1'b0, 5'd12, 64'hDEADBEEFDEADBEEF, 1'b1);

      // Starvation: B waits four cycles, is forced in cycle 4.
      driveA(1'b1, 5'd3, 64'h3333);
      driveB(1'b1, 5'd9, 64'h9999);
      for (int c = 0; c < 6; c++) begin
         #1;
         checkVal($sformatf("t3_aRdy_c%0d", c), 64'(a_ready), 64'(c != 4));
         checkVal($sformatf("t3_bRdy_c%0d", c), 64'(b_ready), 64'(c == 4));
         checkVal($sformatf("t3_starved_c%0d", c), 64'(b_starved), 64'(c == 4));
         step();
         if (c == 4) begin
            driveB(1'b0, 5'd0, 64'd0);
            checkRf($sformatf("t3_c%0d", c), 1'b1, 5'd9, 64'h9999, 1'b1);
         end else begin
            checkRf($sformatf("t3_c%0d", c), 1'b1, 5'd3, 64'h3333, 1'b0);
         end
      end
      driveA(1'b0, 5'd0, 64'd0);
      step();

      // x0 suppression after a write to x7.
      driveA(1'b1, 5'd7, 64'h77);
      step();
      checkRf("t4_pre", 1'b1, 5'd7, 64'h77, 1'b0);
      driveA(1'b1, 5'd0, 64'hEEEEEEEEEEEEEEEE);
      #1;
      checkVal("t4_aRdy", 64'(a_ready), 64'd1);
      step();
      driveA(1'b0, 5'd0, 64'd0);
      checkRf("t4", 1'b0, 5'd7, 64'h77, 1'b0);

      // Same rd from both sources: two sequential writes, B lands last.
      driveA(1'b1, 5'd5, 64'h5A);
      driveB(1'b1, 5'd5, 64'h5B);
      #1;
      checkVal("t7_aRdy", 64'(a_ready), 64'd1);
      step();
      driveA(1'b0, 5'd0, 64'd0);
      checkRf("t7_a", 1'b1, 5'd5, 64'h5A, 1'b0);
      #1;
      checkVal("t7_bRdy", 64'(b_ready), 64'd1);
      step();
      driveB(1'b0, 5'd0, 64'd0);
      checkRf("t7_b", 1'b1, 5'd5, 64'h5B, 1'b1);
      step();

      // Reset mid-operation with partial starvation accumulated.
      driveA(1'b1, 5'd31, '1);
      driveB(1'b1, 5'd9, 64'h99);
      step();
      checkRf("t5_pre", 1'b1, 5'd31, '1, 1'b0);
      driveA(1'b1, 5'd30, 64'h30);
      #2;
      reset = 1'b1;
      #1;
      checkRf("t5_async", 1'b0, 5'd0, 64'd0, 1'b0);
      checkVal("t5_aRdy", 64'(a_ready), 64'd0);
      checkVal("t5_bRdy", 64'(b_ready), 64'd0);
      checkVal("t5_starved", 64'(b_starved), 64'd0);
      step();
      checkVal("t5_held_we", 64'(rf_we), 64'd0);
      checkVal("t5_held_aRdy", 64'(a_ready), 64'd0);
      reset = 1'b0;
      // Counter restarted from zero: B again needs four full waits.
      for (int c = 0; c < 5; c++) begin
         #1;
         checkVal($sformatf("t5_bRdy_c%0d", c), 64'(b_ready), 64'(c == 4));
         checkVal($sformatf("t5_starved_c%0d", c), 64'(b_starved), 64'(c == 4));
         step();
      end
      driveA(1'b0, 5'd0, 64'd0);
      driveB(1'b0, 5'd0, 64'd0);
      checkRf("t5_b", 1'b1, 5'd9, 64'h99, 1'b1);
      step();

      // Idle gaps between A transfers.
      for (int i = 0; i < 4; i++) begin
         expData = 64'h1000_0000_0000_0000 + 64'(i * 17 + 3);
         driveA(1'b1, 5'(i + 1), expData);
         expQ.push_back(expData);
         step();
         driveA(1'b0, 5'd0, 64'd0);
         expData = expQ.pop_front();
         checkRf($sformatf("t6_xfer%0d", i), 1'b1, 5'(i + 1), expData, 1'b0);
         step();
         checkRf($sformatf("t6_idle%0d", i), 1'b0, 5'(i + 1), expData, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checkCnt, errorCnt);
      $finish;
   end

endmodule
